// File: rtl/game_round_ctrl.sv
// game_round_ctrl
// Two-player quiz round sequencer. It shows a question, arms the buzzers,
// arbitrates the first eligible buzz, judges the answer against the question
// table, holds the result for a fixed time, and ends the game on a 5-point
// score or after the last question.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// SHOW   | one-cycle question display; a buzz here is a false start
// ARMED  | buzzers live, timeout counter running
// JUDGE  | one cycle: compare owner's answer, update score or lockout
// RESULT | verdict displayed for RESULT_CYCLES cycles
// DONE   | game over, winner valid, beep high; start begins a new game
module game_round_ctrl #(
    parameter int RESULT_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_btn,
    input  logic       p2_btn,
    input  logic [3:0] p1_ans,
    input  logic [3:0] p2_ans,
    input  logic [3:0] correct_ans,
    output logic [3:0] q_state,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] owner,
    output logic       verdict,
    output logic [1:0] winner,
    output logic       beep
);

    // One shared down-counter serves both the ARMED timeout and the RESULT hold.
    localparam int MAX_CYCLES = (RESULT_CYCLES > TIMEOUT_CYCLES) ? RESULT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    localparam logic [CW-1:0] RESULT_LOAD  = CW'(RESULT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST     = CW'(1);

    localparam logic [3:0] SCORE_MAX = 4'd5;
    localparam logic [3:0] LAST_Q    = 4'd9;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_P1   = 2'b01;
    localparam logic [1:0] OWN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_ARMED,
        S_JUDGE,
        S_RESULT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [3:0]    q_q;
    logic [3:0]    score1_q;
    logic [3:0]    score2_q;
    logic [1:0]    owner_q;
    logic [1:0]    winner_q;
    logic          verdict_q;
    logic          beep_q;
    logic          lock1_q;
    logic          lock2_q;
    logic          prio2_q;      // 0: P1 wins a tie, 1: P2 wins a tie
    logic [CW-1:0] cnt_q;
    logic          btn1_prev_q;
    logic          btn2_prev_q;

    logic          buzz1;
    logic          buzz2;
    logic          elig1;
    logic          elig2;
    logic          tie_buzz;
    logic          grant1;
    logic          grant2;
    logic [3:0]    owner_ans;
    logic          answer_ok;
    logic          other_locked;
    logic          score_full;
    logic          armed_expire;
    logic          result_end;
    logic          next_question;
    logic [1:0]    winner_d;

    // Buzz edge detection, tie arbitration and judgement helpers
    always_comb begin
        buzz1        = p1_btn & ~btn1_prev_q;
        buzz2        = p2_btn & ~btn2_prev_q;
        elig1        = buzz1 & ~lock1_q;
        elig2        = buzz2 & ~lock2_q;
        tie_buzz     = elig1 & elig2;
        grant1       = elig1 & (~elig2 | ~prio2_q);
        grant2       = elig2 & (~elig1 | prio2_q);
        owner_ans    = (owner_q == OWN_P2) ? p2_ans : p1_ans;
        answer_ok    = (owner_ans == correct_ans);
        other_locked = (owner_q == OWN_P2) ? lock1_q : lock2_q;
        score_full   = (score1_q == SCORE_MAX) | (score2_q == SCORE_MAX);

        armed_expire  = (state_q == S_ARMED) & ~(grant1 | grant2) & (cnt_q <= CNT_LAST);
        result_end    = (state_q == S_RESULT) & (cnt_q <= CNT_LAST);
        // A wrong answer re-arms only while the other player may still buzz.
        next_question = armed_expire | (result_end & ~score_full & (verdict_q | other_locked));

        if (score1_q == SCORE_MAX) begin
            winner_d = OWN_P1;
        end else if (score2_q == SCORE_MAX) begin
            winner_d = OWN_P2;
        end else if (score1_q > score2_q) begin
            winner_d = OWN_P1;
        end else if (score2_q > score1_q) begin
            winner_d = OWN_P2;
        end else begin
            winner_d = WIN_TIE;
        end
    end

    // Round FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            q_q         <= 4'd0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            owner_q     <= OWN_NONE;
            winner_q    <= OWN_NONE;
            verdict_q   <= 1'b0;
            beep_q      <= 1'b0;
            lock1_q     <= 1'b0;
            lock2_q     <= 1'b0;
            prio2_q     <= 1'b0;
            cnt_q       <= '0;
            btn1_prev_q <= 1'b0;
            btn2_prev_q <= 1'b0;
        end else begin
            btn1_prev_q <= p1_btn;
            btn2_prev_q <= p2_btn;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_SHOW;
                        q_q       <= 4'd0;
                        score1_q  <= 4'd0;
                        score2_q  <= 4'd0;
                        owner_q   <= OWN_NONE;
                        winner_q  <= OWN_NONE;
                        verdict_q <= 1'b0;
                        beep_q    <= 1'b0;
                        lock1_q   <= 1'b0;
                        lock2_q   <= 1'b0;
                    end
                end

                S_SHOW: begin
                    if (buzz1) begin
                        lock1_q <= 1'b1;
                    end
                    if (buzz2) begin
                        lock2_q <= 1'b1;
                    end
                    cnt_q   <= TIMEOUT_LOAD;
                    state_q <= S_ARMED;
                end

                S_ARMED: begin
                    if (grant1 | grant2) begin
                        owner_q <= grant2 ? OWN_P2 : OWN_P1;
                        if (tie_buzz) begin
                            prio2_q <= ~prio2_q;
                        end
                        state_q <= S_JUDGE;
                    end else if (cnt_q > CNT_LAST) begin
                        cnt_q <= cnt_q - CNT_LAST;
                    end
                end

                S_JUDGE: begin
                    if (answer_ok) begin
                        verdict_q <= 1'b1;
                        if (owner_q == OWN_P2) begin
                            if (score2_q != SCORE_MAX) begin
                                score2_q <= score2_q + 4'd1;
                            end
                        end else if (score1_q != SCORE_MAX) begin
                            score1_q <= score1_q + 4'd1;
                        end
                    end else begin
                        verdict_q <= 1'b0;
                        if (owner_q == OWN_P2) begin
                            lock2_q <= 1'b1;
                        end else begin
                            lock1_q <= 1'b1;
                        end
                    end
                    cnt_q   <= RESULT_LOAD;
                    state_q <= S_RESULT;
                end

                S_RESULT: begin
                    if (!result_end) begin
                        cnt_q <= cnt_q - CNT_LAST;
                    end else begin
                        verdict_q <= 1'b0;
                        if (score_full) begin
                            state_q  <= S_DONE;
                            winner_q <= winner_d;
                            beep_q   <= 1'b1;
                        end else if (!verdict_q && !other_locked) begin
                            cnt_q   <= TIMEOUT_LOAD;
                            state_q <= S_ARMED;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Shared next-question step; the last question ends the game instead of wrapping.
            if (next_question) begin
                lock1_q <= 1'b0;
                lock2_q <= 1'b0;
                owner_q <= OWN_NONE;
                if (q_q == LAST_Q) begin
                    state_q  <= S_DONE;
                    winner_q <= winner_d;
                    beep_q   <= 1'b1;
                end else begin
                    q_q     <= q_q + 4'd1;
                    state_q <= S_SHOW;
                end
            end
        end
    end

    assign q_state  = q_q;
    assign score_p1 = score1_q;
    assign score_p2 = score2_q;
    assign owner    = owner_q;
    assign verdict  = verdict_q;
    assign winner   = winner_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl
// Directed scenarios plus randomized play against a behavioural game model.
module tb_game_round_ctrl;

    localparam int RC = 6;
    localparam int TC = 16;

    localparam int P_IDLE   = 0;
    localparam int P_SHOW   = 1;
    localparam int P_ARMED  = 2;
    localparam int P_JUDGE  = 3;
    localparam int P_RESULT = 4;
    localparam int P_DONE   = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       p1_btn = 1'b0;
    logic       p2_btn = 1'b0;
    logic [3:0] p1_ans = 4'd0;
    logic [3:0] p2_ans = 4'd0;
    logic [3:0] correct_ans = 4'd2;
    logic [3:0] q_state;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] owner;
    logic       verdict;
    logic [1:0] winner;
    logic       beep;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] qtable [10] = '{4'd2, 4'd4, 4'd7, 4'd1, 4'd3, 4'd8, 4'd0, 4'd5, 4'd6, 4'd9};

    // behavioural game model
    int m_ph;
    int m_q;
    int m_score [1:2];
    int m_lock  [1:2];
    int m_prev  [1:2];
    int m_own;
    int m_verd;
    int m_win;
    int m_prio;
    int m_elapsed;

    game_round_ctrl #(
        .RESULT_CYCLES (RC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .p1_btn     (p1_btn),
        .p2_btn     (p2_btn),
        .p1_ans     (p1_ans),
        .p2_ans     (p2_ans),
        .correct_ans(correct_ans),
        .q_state    (q_state),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .owner      (owner),
        .verdict    (verdict),
        .winner     (winner),
        .beep       (beep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decide_winner();
        if (m_score[1] == 5) return 1;
        if (m_score[2] == 5) return 2;
        if (m_score[1] > m_score[2]) return 1;
        if (m_score[2] > m_score[1]) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE;
        m_q = 0;
        m_score[1] = 0; m_score[2] = 0;
        m_lock[1] = 0;  m_lock[2] = 0;
        m_prev[1] = 0;  m_prev[2] = 0;
        m_own = 0;
        m_verd = 0;
        m_win = 0;
        m_prio = 1;
        m_elapsed = 0;
    endtask

    task automatic enter_done();
        m_ph = P_DONE;
        m_win = decide_winner();
    endtask

    task automatic model_next_question();
        m_lock[1] = 0;
        m_lock[2] = 0;
        m_own = 0;
        if (m_q == 9) begin
            enter_done();
        end else begin
            m_q = m_q + 1;
            m_ph = P_SHOW;
        end
    endtask

    task automatic model_step();
        int b [1:2];
        int a [1:2];
        int e1;
        int e2;
        int last_verd;
        b[1] = (p1_btn && m_prev[1] == 0) ? 1 : 0;
        b[2] = (p2_btn && m_prev[2] == 0) ? 1 : 0;
        m_prev[1] = int'(p1_btn);
        m_prev[2] = int'(p2_btn);
        a[1] = int'(p1_ans);
        a[2] = int'(p2_ans);
        case (m_ph)
            P_IDLE, P_DONE: begin
                if (start) begin
                    m_score[1] = 0; m_score[2] = 0;
                    m_lock[1] = 0;  m_lock[2] = 0;
                    m_q = 0; m_own = 0; m_verd = 0; m_win = 0;
                    m_ph = P_SHOW;
                end
            end
            P_SHOW: begin
                for (int p = 1; p <= 2; p++) begin
                    if (b[p] != 0) m_lock[p] = 1;
                end
                m_ph = P_ARMED;
                m_elapsed = 0;
            end
            P_ARMED: begin
                e1 = (b[1] != 0 && m_lock[1] == 0) ? 1 : 0;
                e2 = (b[2] != 0 && m_lock[2] == 0) ? 1 : 0;
                if (e1 != 0 && e2 != 0) begin
                    m_own = m_prio;
                    m_prio = 3 - m_prio;
                    m_ph = P_JUDGE;
                end else if (e1 != 0) begin
                    m_own = 1;
                    m_ph = P_JUDGE;
                end else if (e2 != 0) begin
                    m_own = 2;
                    m_ph = P_JUDGE;
                end else begin
                    m_elapsed++;
                    if (m_elapsed >= TC) model_next_question();
                end
            end
            P_JUDGE: begin
                if (a[m_own] == int'(correct_ans)) begin
                    m_verd = 1;
                    if (m_score[m_own] < 5) m_score[m_own]++;
                end else begin
                    m_verd = 0;
                    m_lock[m_own] = 1;
                end
                m_ph = P_RESULT;
                m_elapsed = 0;
            end
            P_RESULT: begin
                m_elapsed++;
                if (m_elapsed >= RC) begin
                    last_verd = m_verd;
                    m_verd = 0;
                    if (m_score[1] == 5 || m_score[2] == 5) begin
                        enter_done();
                    end else if (last_verd == 0 && m_lock[3 - m_own] == 0) begin
                        m_ph = P_ARMED;
                        m_elapsed = 0;
                    end else begin
                        model_next_question();
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cyc_q_state",  int'(q_state),  m_q);
                chk("cyc_score_p1", int'(score_p1), m_score[1]);
                chk("cyc_score_p2", int'(score_p2), m_score[2]);
                chk("cyc_owner",    int'(owner),    m_own);
                chk("cyc_verdict",  int'(verdict),  m_verd);
                chk("cyc_winner",   int'(winner),   m_win);
                chk("cyc_beep",     int'(beep),     (m_ph == P_DONE) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        correct_ans = qtable[m_q];
    endtask

    task automatic apply_reset();
        start = 1'b0;
        p1_btn = 1'b0;
        p2_btn = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            tick();
            n++;
        end
        if (m_ph != ph) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s wait expired actual_phase=%0d required_phase=%0d", name, m_ph, ph);
        end
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_q_state"},  int'(q_state),  0);
        chk({tag, "_score_p1"}, int'(score_p1), 0);
        chk({tag, "_score_p2"}, int'(score_p2), 0);
        chk({tag, "_owner"},    int'(owner),    0);
        chk({tag, "_verdict"},  int'(verdict),  0);
        chk({tag, "_winner"},   int'(winner),   0);
        chk({tag, "_beep"},     int'(beep),     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk_all_reset("rst");
        tick();
        chk_all_reset("rel");

        // correct first buzz, result hold, next question
        start = 1'b1; tick(); start = 1'b0;
        tick();
        p1_ans = 4'd2; p1_btn = 1'b1; tick();
        chk("a_owner", int'(owner), 1);
        chk("a_score_pre", int'(score_p1), 0);
        p1_btn = 1'b0; tick();
        chk("a_score_p1", int'(score_p1), 1);
        chk("a_verdict", int'(verdict), 1);
        repeat (RC - 1) tick();
        chk("a_hold_q", int'(q_state), 0);
        chk("a_hold_verdict", int'(verdict), 1);
        tick();
        chk("a_next_q", int'(q_state), 1);
        chk("a_owner_clr", int'(owner), 0);

        // wrong answer, re-arm, locked re-buzz ignored, other player correct
        tick();
        p1_ans = 4'd3; p1_btn = 1'b1; tick();
        p1_btn = 1'b0; tick();
        chk("b_verdict", int'(verdict), 0);
        chk("b_score_p1", int'(score_p1), 1);
        repeat (RC) tick();
        chk("b_rearm_q", int'(q_state), 1);
        p1_ans = 4'd4; p1_btn = 1'b1; tick();
        p1_btn = 1'b0; tick();
        chk("b_ignore_score", int'(score_p1), 1);
        p2_ans = 4'd4; p2_btn = 1'b1; tick();
        chk("b_owner_p2", int'(owner), 2);
        p2_btn = 1'b0; tick();
        chk("b_score_p2", int'(score_p2), 1);
        chk("b_verdict_p2", int'(verdict), 1);
        wait_phase(P_SHOW, RC + 2, "b_next");
        chk("b_next_q", int'(q_state), 2);

        // simultaneous buzzes on two questions: priority alternates
        tick();
        p1_ans = qtable[2]; p2_ans = qtable[2];
        p1_btn = 1'b1; p2_btn = 1'b1; tick();
        chk("c_first_owner", int'(owner), 1);
        p1_btn = 1'b0; p2_btn = 1'b0;
        wait_phase(P_SHOW, RC + 3, "c_q3");
        tick();
        p1_ans = qtable[3]; p2_ans = qtable[3];
        p1_btn = 1'b1; p2_btn = 1'b1; tick();
        chk("c_second_owner", int'(owner), 2);
        p1_btn = 1'b0; p2_btn = 1'b0;
        wait_phase(P_SHOW, RC + 3, "c_q4");
        chk("c_score_p1", int'(score_p1), 2);
        chk("c_score_p2", int'(score_p2), 2);
        chk("c_q4", int'(q_state), 4);

        // false start in SHOW, then timeout
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        p2_btn = 1'b1; tick();
        p2_btn = 1'b0; tick();
        p2_ans = qtable[0]; p2_btn = 1'b1; tick();
        p2_btn = 1'b0;
        chk("d_owner", int'(owner), 0);
        repeat (TC - 3) tick();
        chk("d_hold_q", int'(q_state), 0);
        tick();
        chk("d_next_q", int'(q_state), 1);
        chk("d_score_p2", int'(score_p2), 0);

        // five correct answers end the game
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_phase(P_ARMED, 4, "e_arm");
            p1_ans = qtable[m_q]; p1_btn = 1'b1; tick();
            p1_btn = 1'b0; tick();
            if (i < 4) wait_phase(P_SHOW, RC + 2, "e_next");
            else       wait_phase(P_DONE, RC + 2, "e_done");
        end
        chk("e_score_p1", int'(score_p1), 5);
        chk("e_winner", int'(winner), 1);
        chk("e_beep", int'(beep), 1);
        chk("e_q_state", int'(q_state), 4);
        tick();
        chk("e_beep_hold", int'(beep), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("e_restart_score", int'(score_p1), 0);
        chk("e_restart_q", int'(q_state), 0);
        chk("e_restart_beep", int'(beep), 0);

        // all questions time out; then asynchronous reset mid-RESULT
        apply_reset();
        start = 1'b1; tick(); start = 1'b0;
        wait_phase(P_DONE, 10 * (TC + 1) + 5, "f_done");
        chk("f_q_state", int'(q_state), 9);
        chk("f_winner", int'(winner), 3);
        chk("f_beep", int'(beep), 1);
        start = 1'b1; tick(); start = 1'b0;
        wait_phase(P_ARMED, 4, "f_arm");
        p1_ans = qtable[m_q]; p1_btn = 1'b1; tick();
        p1_btn = 1'b0; tick();
        repeat (2) tick();
        chk("f_pre_verdict", int'(verdict), 1);
        chk("f_pre_owner", int'(owner), 1);
        #3 rst_n = 1'b0;
        #1 chk_all_reset("f_async");
        tick();
        tick();
        rst_n = 1'b1;

        // randomized play
        for (int c = 0; c < 6000; c++) begin
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 4) == 0) p1_btn = ~p1_btn;
            if ($urandom_range(0, 4) == 0) p2_btn = ~p2_btn;
            p1_ans = ($urandom_range(0, 2) != 0) ? qtable[m_q] : 4'($urandom_range(0, 9));
            p2_ans = ($urandom_range(0, 2) != 0) ? qtable[m_q] : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter RESULT_CYCLES, default 50, cycles the RESULT state is held per judgement.
REQ-002 Parameter TIMEOUT_CYCLES, default 500, cycles ARMED waits for a buzz before the question is abandoned.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  level; begins a game from IDLE or DONE.
REQ-006 p1_btn, p2_btn  in  1 each  player buzzers; synchronous active-high levels.
REQ-007 p1_ans, p2_ans  in  4 each  BCD answer selected by each player.
REQ-008 correct_ans  in  4  BCD answer from the question table for the current q_state.
REQ-009 q_state  out  4  question index 0..9 driven to the question table.
REQ-010 score_p1, score_p2  out  4 each  BCD scores 0..5.
REQ-011 owner  out  2  player being judged or last judged: 00 none, 01 P1, 10 P2.
REQ-012 verdict  out  1  1 = last judgement correct; valid in RESULT only.
REQ-013 winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid in DONE.
REQ-014 beep  out  1  high exactly while in DONE.

Function
REQ-015 States SHALL be IDLE, SHOW, ARMED, JUDGE, RESULT, DONE.
REQ-016 IDLE/DONE -> SHOW when start=1; scores cleared to 0, q_state=0, lockouts cleared.
REQ-017 SHOW lasts exactly 1 cycle, then ARMED with the timeout counter loaded to TIMEOUT_CYCLES.
REQ-018 Buzz = rising edge of pN_btn (registered previous sample); levels held high produce no further buzz.
REQ-019 A buzz in SHOW SHALL lock out that player for the current question (false start).
REQ-020 In ARMED, a buzz from a non-locked player SHALL move to JUDGE on the next edge and latch owner.
REQ-021 Simultaneous eligible buzzes: grant to the priority player; priority starts at P1 after reset and toggles after every simultaneous grant.
REQ-022 Buzzes from locked players, or during JUDGE/RESULT/IDLE/DONE, SHALL be ignored.
REQ-023 JUDGE lasts 1 cycle: owner's pN_ans == correct_ans -> verdict=1 and owner's score +1; else verdict=0 and owner locked out.
REQ-024 Scores SHALL saturate at 5; a score reaching 5 -> DONE after RESULT, with that player as winner.
REQ-025 RESULT holds RESULT_CYCLES cycles, then: winner found -> DONE; verdict=1 -> next question; verdict=0 and other player not locked -> ARMED with timeout reloaded; otherwise next question.
REQ-026 ARMED timeout reaching 0 with no buzz SHALL advance to next question, no score change.
REQ-027 Next question: q_state+1, clear lockouts, owner=00, enter SHOW; from q_state=9 go to DONE instead (no wrap).
REQ-028 DONE without a 5-score: winner by higher score; equal scores -> 11.
REQ-029 start while not in IDLE/DONE SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, q_state=0, scores 0, owner=00, verdict=0, winner=00, beep=0, lockouts cleared, priority=P1, counters 0, previous-button registers 0.
REQ-031 Reset mid-game SHALL discard all progress; no output change on the first edge after release unless start=1.

Verification
REQ-032 Reset, start, P1 buzzes in ARMED with p1_ans=correct_ans=2 -> JUDGE next edge, score_p1=1, verdict=1, after RESULT_CYCLES q_state=1.
REQ-033 P1 and P2 rising edges same cycle twice in ARMED (two questions) -> owner=01 first, owner=10 second.
REQ-034 P1 buzzes wrong (p1_ans=3, correct_ans=4) -> verdict=0, back to ARMED; P1 re-buzz ignored; P2 correct -> score_p2=1.
REQ-035 P2 pressed during SHOW, then no P1 buzz for TIMEOUT_CYCLES -> P2 buzz ignored, q_state advances, scores unchanged.
REQ-036 P1 answers 5 questions correctly -> score_p1=5, DONE, winner=01, beep=1; start -> scores 0, q_state=0, beep=0.
REQ-037 All 10 questions time out -> DONE from q_state=9, winner=11; rst_n pulsed mid-RESULT -> all outputs at reset values asynchronously.
